// File: rtl/hawk_tol_ht_mngr.sv
`default_nettype none
// ============================================================================
//  Module   : hawk_tol_ht_mngr
//  Purpose  : Head/tail manager for singly linked entry lists (POP_HEAD /
//             PUSH_TAIL), with list initialisation walk after reset.
//             Optional per-list occupancy counters: HACD_TOL_CNT_EN
//  Revision : 1.0 - initial release
// ============================================================================
module hawk_tol_ht_mngr #(
  parameter  int NUM_IFL       = 1,
  parameter  int ID_W          = 18,
  parameter  int INIT_FREE_CNT = 4,
  localparam int NUM_LISTS     = 4 + NUM_IFL,
  localparam int LIST_W        = ($clog2(NUM_LISTS) > 3) ? $clog2(NUM_LISTS) : 3,
  localparam int CNT_W         = ID_W + 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic                       req_op_i,
  input  logic [LIST_W-1:0]          req_list_i,
  input  logic [ID_W-1:0]            req_id_i,
  output logic                       resp_valid_o,
  output logic [ID_W-1:0]            resp_id_o,
  output logic                       resp_err_o,
  output logic [NUM_LISTS*ID_W-1:0]  head_o,
  output logic [NUM_LISTS*ID_W-1:0]  tail_o,
  output logic [NUM_LISTS-1:0]       empty_o,
  output logic [NUM_LISTS*CNT_W-1:0] count_o,
  output logic                       init_done_o
);

  localparam int                c_LST_NULLIFY = 0;
  localparam int                c_LST_FREE    = 1;
  localparam logic              c_OP_PUSH     = 1'b1;
  localparam logic [ID_W-1:0]   c_NULL        = '0;
  localparam logic [LIST_W-1:0] c_LAST_IDX    = LIST_W'(NUM_LISTS - 1);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [LIST_W-1:0]   r_init_idx;
  logic [LIST_W-1:0]   w_init_idx_nxt;
  logic                w_ready;

  logic [ID_W-1:0]     w_head [NUM_LISTS];
  logic [ID_W-1:0]     w_tail [NUM_LISTS];
  logic [NUM_LISTS-1:0] w_sel;
  logic [NUM_LISTS-1:0] w_init_wr;
  logic [NUM_LISTS-1:0] w_upd;

  logic                w_accept;
  logic                w_list_ok;
  logic [ID_W-1:0]     w_old_head;
  logic [ID_W-1:0]     w_old_tail;
  logic                w_old_empty;
  logic                w_cnt_full;
  logic                w_err;
  logic                w_do;
  logic [ID_W-1:0]     w_head_nxt;
  logic [ID_W-1:0]     w_tail_nxt;
  logic [ID_W-1:0]     w_resp_id;

  logic                r_resp_valid;
  logic                r_resp_err;
  logic [ID_W-1:0]     r_resp_id;

  // --------------------------------------------------------------------------
  // Control FSM: walk every list once after reset, then serve requests
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= ST_INIT;
      r_init_idx <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_init_idx <= w_init_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_init_idx_nxt = r_init_idx;
    w_ready        = 1'b0;
    case (r_state)
      ST_INIT: begin
        if (r_init_idx == c_LAST_IDX) begin
          w_state_nxt    = ST_IDLE;
          w_init_idx_nxt = '0;
        end else begin
          w_init_idx_nxt = r_init_idx + LIST_W'(1);
        end
      end
      ST_IDLE: begin
        w_ready = 1'b1;
      end
      default: begin
        w_state_nxt = ST_INIT;
      end
    endcase
  end

  assign req_ready_o = w_ready;
  assign init_done_o = (r_state == ST_IDLE);
  assign w_accept    = req_valid_i && w_ready;

  // --------------------------------------------------------------------------
  // Request decode; code 0 and codes past the last list select nothing
  // --------------------------------------------------------------------------
  always_comb begin
    w_sel     = '0;
    w_init_wr = '0;
    for (int i = 0; i < NUM_LISTS; i++) begin
      w_sel[i]     = (i != c_LST_NULLIFY) && (req_list_i == LIST_W'(i));
      w_init_wr[i] = (r_state == ST_INIT) && (r_init_idx == LIST_W'(i));
    end
  end

  assign w_list_ok = |w_sel;

  always_comb begin
    w_old_head = c_NULL;
    w_old_tail = c_NULL;
    for (int i = 0; i < NUM_LISTS; i++) begin
      if (w_sel[i]) begin
        w_old_head = w_head[i];
        w_old_tail = w_tail[i];
      end
    end
  end

  assign w_old_empty = (w_old_head == c_NULL);

  always_comb begin
    w_err = 1'b0;
    if (!w_list_ok) begin
      w_err = 1'b1;
    end else if (req_op_i == c_OP_PUSH) begin
      w_err = (req_id_i == c_NULL) || w_cnt_full;
    end else begin
      w_err = w_old_empty;
    end
  end

  assign w_do  = w_accept && !w_err;
  assign w_upd = w_do ? w_sel : '0;

  // Only the selected list is written, so one shared next-value is enough
  always_comb begin
    w_head_nxt = w_old_head;
    w_tail_nxt = w_old_tail;
    w_resp_id  = w_old_head;
    if (req_op_i == c_OP_PUSH) begin
      w_resp_id  = w_old_tail;
      w_tail_nxt = req_id_i;
      if (w_old_empty) begin
        w_head_nxt = req_id_i;
      end
    end else if (w_old_head == w_old_tail) begin
      w_head_nxt = c_NULL;
      w_tail_nxt = c_NULL;
    end else begin
      w_head_nxt = req_id_i;
    end
  end

  // --------------------------------------------------------------------------
  // Per-list head/tail (and optional occupancy) registers
  // --------------------------------------------------------------------------
`ifdef HACD_TOL_CNT_EN
  localparam logic [CNT_W-1:0] c_CNT_MAX = {1'b0, {ID_W{1'b1}}};
  logic [CNT_W-1:0] w_cnt [NUM_LISTS];
  logic [CNT_W-1:0] w_old_cnt;

  always_comb begin
    w_old_cnt = '0;
    for (int i = 0; i < NUM_LISTS; i++) begin
      if (w_sel[i]) begin
        w_old_cnt = w_cnt[i];
      end
    end
  end

  assign w_cnt_full = (w_old_cnt == c_CNT_MAX);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < NUM_LISTS; i++) begin
      count_o[i*CNT_W +: CNT_W] = w_cnt[i];
    end
  end
`else
  assign w_cnt_full = 1'b0;
  assign count_o    = '0;
`endif

  generate
    for (genvar i = 0; i < NUM_LISTS; i++) begin : g_list
      localparam logic [ID_W-1:0] c_INIT_HEAD = (i == c_LST_FREE) ? ID_W'(1) : c_NULL;
      localparam logic [ID_W-1:0] c_INIT_TAIL = (i == c_LST_FREE) ? ID_W'(INIT_FREE_CNT) : c_NULL;
      logic [ID_W-1:0] r_head;
      logic [ID_W-1:0] r_tail;

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          r_head <= c_NULL;
          r_tail <= c_NULL;
        end else if (w_init_wr[i]) begin
          r_head <= c_INIT_HEAD;
          r_tail <= c_INIT_TAIL;
        end else if (w_upd[i]) begin
          r_head <= w_head_nxt;
          r_tail <= w_tail_nxt;
        end
      end

      assign w_head[i] = r_head;
      assign w_tail[i] = r_tail;

`ifdef HACD_TOL_CNT_EN
      localparam logic [CNT_W-1:0] c_INIT_CNT = (i == c_LST_FREE) ? CNT_W'(INIT_FREE_CNT) : '0;
      logic [CNT_W-1:0] r_cnt;

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          r_cnt <= '0;
        end else if (w_init_wr[i]) begin
          r_cnt <= c_INIT_CNT;
        end else if (w_upd[i]) begin
          r_cnt <= (req_op_i == c_OP_PUSH) ? r_cnt + CNT_W'(1) : r_cnt - CNT_W'(1);
        end
      end

      assign w_cnt[i] = r_cnt;
`endif
    end
  endgenerate

  always_comb begin
    head_o  = '0;
    tail_o  = '0;
    empty_o = '0;
    for (int i = 0; i < NUM_LISTS; i++) begin
      head_o[i*ID_W +: ID_W] = w_head[i];
      tail_o[i*ID_W +: ID_W] = w_tail[i];
      empty_o[i]             = (w_head[i] == c_NULL);
    end
  end

  // --------------------------------------------------------------------------
  // Registered response; id/err are forced low outside the strobe
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_id    <= c_NULL;
    end else begin
      r_resp_valid <= w_accept;
      r_resp_err   <= w_accept && w_err;
      r_resp_id    <= w_do ? w_resp_id : c_NULL;
    end
  end

  assign resp_valid_o = r_resp_valid;
  assign resp_err_o   = r_resp_err;
  assign resp_id_o    = r_resp_id;

endmodule
`default_nettype wire

// File: tb/tb_hawk_tol_ht_mngr.sv
`default_nettype none
// Directed self-checking bench for hawk_tol_ht_mngr (NUM_IFL=1, ID_W=18, 4 free entries).
module tb_hawk_tol_ht_mngr;

  localparam int ID_W  = 18;
  localparam int NL    = 5;
  localparam int CNT_W = 19;
`ifdef HACD_TOL_CNT_EN
  localparam int CNT_ON = 1;
`else
  localparam int CNT_ON = 0;
`endif

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic               req_valid_i;
  logic               req_ready_o;
  logic               req_op_i;
  logic [2:0]         req_list_i;
  logic [ID_W-1:0]    req_id_i;
  logic               resp_valid_o;
  logic [ID_W-1:0]    resp_id_o;
  logic               resp_err_o;
  logic [NL*ID_W-1:0] head_o;
  logic [NL*ID_W-1:0] tail_o;
  logic [NL-1:0]      empty_o;
  logic [NL*CNT_W-1:0] count_o;
  logic               init_done_o;

  int checks   = 0;
  int failures = 0;

  hawk_tol_ht_mngr #(.NUM_IFL(1), .ID_W(ID_W), .INIT_FREE_CNT(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_op_i(req_op_i), .req_list_i(req_list_i), .req_id_i(req_id_i),
    .resp_valid_o(resp_valid_o), .resp_id_o(resp_id_o), .resp_err_o(resp_err_o),
    .head_o(head_o), .tail_o(tail_o), .empty_o(empty_o), .count_o(count_o),
    .init_done_o(init_done_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [ID_W-1:0] hd(input int l);
    return head_o[l*ID_W +: ID_W];
  endfunction
  function automatic logic [ID_W-1:0] tl(input int l);
    return tail_o[l*ID_W +: ID_W];
  endfunction
  function automatic logic [CNT_W-1:0] cn(input int l);
    return count_o[l*CNT_W +: CNT_W];
  endfunction

  // Called at a falling edge; returns at the next falling edge with the response visible.
  task automatic send(input logic op, input logic [2:0] lst, input logic [ID_W-1:0] id);
    req_valid_i = 1'b1;
    req_op_i    = op;
    req_list_i  = lst;
    req_id_i    = id;
    @(negedge clk_i);
    req_valid_i = 1'b0;
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    req_valid_i = 1'b1; req_op_i = 1'b1; req_list_i = 3'd2; req_id_i = 18'd3;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    checks++; if (req_ready_o !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", req_ready_o); end
    checks++; if (resp_valid_o !== 1'b0 || resp_id_o !== 18'd0 || resp_err_o !== 1'b0) begin failures++; $display("FAIL rst_resp got v=%b id=%0d e=%b exp 0/0/0", resp_valid_o, resp_id_o, resp_err_o); end
    checks++; if (init_done_o !== 1'b0) begin failures++; $display("FAIL rst_init_done got=%b exp=0", init_done_o); end
    checks++; if (head_o !== '0 || tail_o !== '0 || count_o !== '0) begin failures++; $display("FAIL rst_regs got head=%h tail=%h cnt=%h exp all 0", head_o, tail_o, count_o); end
    checks++; if (empty_o !== 5'b11111) begin failures++; $display("FAIL rst_empty got=%b exp=11111", empty_o); end
  endtask

  task automatic test_init;
    rst_i = 1'b0;
    req_valid_i = 1'b0;
    repeat (4) @(posedge clk_i);
    #1;
    checks++; if (init_done_o !== 1'b0 || req_ready_o !== 1'b0) begin failures++; $display("FAIL init_early got done=%b rdy=%b exp 0/0", init_done_o, req_ready_o); end
    @(posedge clk_i);
    #1;
    checks++; if (init_done_o !== 1'b1 || req_ready_o !== 1'b1) begin failures++; $display("FAIL init_done5 got done=%b rdy=%b exp 1/1", init_done_o, req_ready_o); end
    @(negedge clk_i);
    checks++; if (hd(1) !== 18'd1 || tl(1) !== 18'd4) begin failures++; $display("FAIL init_free got h=%0d t=%0d exp h=1 t=4", hd(1), tl(1)); end
    checks++; if (empty_o !== 5'b11101) begin failures++; $display("FAIL init_empty got=%b exp=11101", empty_o); end
    checks++; if (hd(2) !== 0 || tl(3) !== 0 || hd(4) !== 0) begin failures++; $display("FAIL init_others got h2=%0d t3=%0d h4=%0d exp 0", hd(2), tl(3), hd(4)); end
    checks++; if (cn(1) !== CNT_W'(4*CNT_ON) || cn(2) !== '0) begin failures++; $display("FAIL init_count got c1=%0d c2=%0d exp c1=%0d c2=0", cn(1), cn(2), 4*CNT_ON); end
  endtask

  task automatic test_pop_push;
    send(1'b0, 3'd1, 18'd2);
    checks++; if (resp_valid_o !== 1'b1 || resp_id_o !== 18'd1 || resp_err_o !== 1'b0) begin failures++; $display("FAIL pop_free got v=%b id=%0d e=%b exp 1/1/0", resp_valid_o, resp_id_o, resp_err_o); end
    checks++; if (hd(1) !== 18'd2 || tl(1) !== 18'd4) begin failures++; $display("FAIL pop_free_state got h=%0d t=%0d exp h=2 t=4", hd(1), tl(1)); end
    send(1'b1, 3'd2, 18'd1);
    checks++; if (resp_valid_o !== 1'b1 || resp_id_o !== 18'd0 || resp_err_o !== 1'b0) begin failures++; $display("FAIL push_uncomp got v=%b id=%0d e=%b exp 1/0/0", resp_valid_o, resp_id_o, resp_err_o); end
    checks++; if (hd(2) !== 18'd1 || tl(2) !== 18'd1 || empty_o[2] !== 1'b0) begin failures++; $display("FAIL push_uncomp_state got h=%0d t=%0d e=%b exp 1/1/0", hd(2), tl(2), empty_o[2]); end
    @(negedge clk_i);
    checks++; if (resp_valid_o !== 1'b0 || resp_id_o !== 18'd0 || resp_err_o !== 1'b0) begin failures++; $display("FAIL resp_idle got v=%b id=%0d e=%b exp 0/0/0", resp_valid_o, resp_id_o, resp_err_o); end
    send(1'b0, 3'd2, 18'd77);
    checks++; if (resp_id_o !== 18'd1 || hd(2) !== 18'd0 || tl(2) !== 18'd0 || empty_o[2] !== 1'b1) begin failures++; $display("FAIL pop_single got id=%0d h=%0d t=%0d e=%b exp 1/0/0/1", resp_id_o, hd(2), tl(2), empty_o[2]); end
  endtask

  task automatic test_back_to_back;
    send(1'b1, 3'd2, 18'd5);
    checks++; if (resp_valid_o !== 1'b1 || resp_id_o !== 18'd0) begin failures++; $display("FAIL b2b_first got v=%b id=%0d exp 1/0", resp_valid_o, resp_id_o); end
    send(1'b1, 3'd2, 18'd6);
    checks++; if (resp_valid_o !== 1'b1 || resp_id_o !== 18'd5 || resp_err_o !== 1'b0) begin failures++; $display("FAIL b2b_second got v=%b id=%0d e=%b exp 1/5/0", resp_valid_o, resp_id_o, resp_err_o); end
    checks++; if (hd(2) !== 18'd5 || tl(2) !== 18'd6) begin failures++; $display("FAIL b2b_state got h=%0d t=%0d exp h=5 t=6", hd(2), tl(2)); end
    checks++; if (cn(2) !== CNT_W'(2*CNT_ON)) begin failures++; $display("FAIL b2b_count got=%0d exp=%0d", cn(2), 2*CNT_ON); end
  endtask

  task automatic test_errors;
    send(1'b0, 3'd3, 18'd8);
    checks++; if (resp_valid_o !== 1'b1 || resp_err_o !== 1'b1 || resp_id_o !== 18'd0) begin failures++; $display("FAIL pop_empty got v=%b e=%b id=%0d exp 1/1/0", resp_valid_o, resp_err_o, resp_id_o); end
    checks++; if (hd(3) !== 0 || tl(3) !== 0 || empty_o[3] !== 1'b1) begin failures++; $display("FAIL pop_empty_state got h=%0d t=%0d e=%b exp 0/0/1", hd(3), tl(3), empty_o[3]); end
    send(1'b0, 3'd0, 18'd8);
    checks++; if (resp_err_o !== 1'b1 || resp_id_o !== 18'd0) begin failures++; $display("FAIL pop_code0 got e=%b id=%0d exp 1/0", resp_err_o, resp_id_o); end
    send(1'b0, 3'd5, 18'd8);
    checks++; if (resp_err_o !== 1'b1 || resp_id_o !== 18'd0) begin failures++; $display("FAIL pop_code5 got e=%b id=%0d exp 1/0", resp_err_o, resp_id_o); end
    send(1'b1, 3'd7, 18'd8);
    checks++; if (resp_err_o !== 1'b1) begin failures++; $display("FAIL push_code7 got e=%b exp 1", resp_err_o); end
    send(1'b1, 3'd4, 18'd0);
    checks++; if (resp_err_o !== 1'b1 || empty_o[4] !== 1'b1) begin failures++; $display("FAIL push_null got e=%b empty4=%b exp 1/1", resp_err_o, empty_o[4]); end
    checks++; if (hd(2) !== 18'd5 || tl(2) !== 18'd6 || hd(1) !== 18'd2) begin failures++; $display("FAIL err_nochange got h2=%0d t2=%0d h1=%0d exp 5/6/2", hd(2), tl(2), hd(1)); end
    send(1'b1, 3'd4, 18'd7);
    checks++; if (resp_err_o !== 1'b0 || resp_id_o !== 18'd0 || hd(4) !== 18'd7 || tl(4) !== 18'd7) begin failures++; $display("FAIL push_ifl got e=%b id=%0d h=%0d t=%0d exp 0/0/7/7", resp_err_o, resp_id_o, hd(4), tl(4)); end
  endtask

  task automatic test_drain;
    send(1'b0, 3'd1, 18'd3);
    checks++; if (resp_id_o !== 18'd2 || hd(1) !== 18'd3) begin failures++; $display("FAIL drain1 got id=%0d h=%0d exp 2/3", resp_id_o, hd(1)); end
    send(1'b0, 3'd1, 18'd4);
    checks++; if (resp_id_o !== 18'd3 || hd(1) !== 18'd4 || tl(1) !== 18'd4) begin failures++; $display("FAIL drain2 got id=%0d h=%0d t=%0d exp 3/4/4", resp_id_o, hd(1), tl(1)); end
    send(1'b0, 3'd1, 18'd9);
    checks++; if (resp_id_o !== 18'd4 || resp_err_o !== 1'b0 || hd(1) !== 0 || tl(1) !== 0 || empty_o[1] !== 1'b1) begin failures++; $display("FAIL drain_last got id=%0d e=%b h=%0d t=%0d emp=%b exp 4/0/0/0/1", resp_id_o, resp_err_o, hd(1), tl(1), empty_o[1]); end
    checks++; if (cn(1) !== '0) begin failures++; $display("FAIL drain_count got=%0d exp=0", cn(1)); end
    send(1'b0, 3'd1, 18'd9);
    checks++; if (resp_err_o !== 1'b1 || resp_id_o !== 18'd0) begin failures++; $display("FAIL drain_underflow got e=%b id=%0d exp 1/0", resp_err_o, resp_id_o); end
  endtask

  task automatic test_reset_mid_op;
    int n;
    send(1'b1, 3'd1, 18'd10);
    send(1'b0, 3'd1, 18'd11);
    checks++; if (resp_valid_o !== 1'b1 || resp_id_o !== 18'd10) begin failures++; $display("FAIL mid_pop got v=%b id=%0d exp 1/10", resp_valid_o, resp_id_o); end
    rst_i = 1'b1;
    @(negedge clk_i);
    checks++; if (resp_valid_o !== 1'b0 || req_ready_o !== 1'b0 || init_done_o !== 1'b0) begin failures++; $display("FAIL mid_rst got v=%b rdy=%b done=%b exp 0/0/0", resp_valid_o, req_ready_o, init_done_o); end
    rst_i = 1'b0;
    n = 0;
    while (init_done_o !== 1'b1 && n < 20) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    checks++; if (n !== 5 || init_done_o !== 1'b1) begin failures++; $display("FAIL mid_reinit got cycles=%0d done=%b exp 5/1", n, init_done_o); end
    @(negedge clk_i);
    checks++; if (hd(1) !== 18'd1 || tl(1) !== 18'd4 || hd(2) !== 0 || hd(4) !== 0) begin failures++; $display("FAIL mid_restore got h1=%0d t1=%0d h2=%0d h4=%0d exp 1/4/0/0", hd(1), tl(1), hd(2), hd(4)); end
    checks++; if (cn(1) !== CNT_W'(4*CNT_ON) || cn(2) !== '0) begin failures++; $display("FAIL mid_count got c1=%0d c2=%0d exp %0d/0", cn(1), cn(2), 4*CNT_ON); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_init();
    test_pop_push();
    test_back_to_back();
    test_errors();
    test_drain();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hawk_tol_ht_mngr.md
HAWK_TOL_HT_MNGR -- requirements
Module: hawk_tol_ht_mngr

Interface
REQ-001 SHALL have parameter NUM_IFL, default 1: number of irregular free lists.
REQ-002 SHALL have parameter ID_W, default 18: list entry id width, equal to clogb2(LST_ENTRY_MAX).
REQ-003 SHALL have parameter INIT_FREE_CNT, default 4: number of entries placed on the FREE list at init, equal to LIST_ENTRY_CNT.
REQ-004 SHALL derive NUM_LISTS = 4+NUM_IFL, LIST_W = max(3, clogb2(NUM_LISTS)) and CNT_W = ID_W+1 as localparams.
REQ-005 SHALL use list codes NULLIFY=0, FREE=1, UNCOMP=2, INCOMP=3, and IFL k = 4+k.
REQ-006 clk_i  in  1  sole clock, rising edge.
REQ-007 rst_i  in  1  reset, synchronous, active-high.
REQ-008 req_valid_i  in  1  operation request.
REQ-009 req_ready_o  out  1  block can accept a request.
REQ-010 req_op_i  in  1  0 = POP_HEAD, 1 = PUSH_TAIL.
REQ-011 req_list_i  in  LIST_W  target list code.
REQ-012 req_id_i  in  ID_W  PUSH: entry id to append; POP: ListEntry.next of the current head, which becomes the new head.
REQ-013 resp_valid_o  out  1  one-cycle response strobe.
REQ-014 resp_id_o  out  ID_W  POP: the popped head id; PUSH: the previous tail id, for prev/next linking.
REQ-015 resp_err_o  out  1  the operation was rejected and list state is unchanged.
REQ-016 head_o  out  NUM_LISTS*ID_W  per-list head, with list i at bits [i*ID_W +: ID_W].
REQ-017 tail_o  out  NUM_LISTS*ID_W  per-list tail, same packing as head_o.
REQ-018 empty_o  out  NUM_LISTS  per-list flag, high when head equals NULL (0).
REQ-019 count_o  out  NUM_LISTS*CNT_W  per-list occupancy (see Configuration).
REQ-020 init_done_o  out  1  initialisation is complete.

Function
REQ-021 The FSM SHALL have states INIT and IDLE; rst_i forces INIT with the walk index at 0.
REQ-022 INIT SHALL write one list per cycle, index 0 to NUM_LISTS-1, and then move to IDLE; init_done_o SHALL rise on the cycle the FSM enters IDLE.
REQ-023 INIT SHALL set list FREE to head=1, tail=INIT_FREE_CNT, count=INIT_FREE_CNT.
REQ-024 INIT SHALL set every other list to head=tail=NULL, count=0.
REQ-025 req_ready_o SHALL be 0 in INIT and 1 in IDLE; a request is accepted when req_valid_i and req_ready_o are both high.
REQ-026 List registers SHALL update on the accepting edge.
REQ-027 resp_valid_o, resp_id_o and resp_err_o SHALL be driven exactly 1 cycle after acceptance; there is no response backpressure.
REQ-028 Throughput SHALL be 1 operation per cycle; a back-to-back operation on the same list SHALL see the state updated by the previous operation.
REQ-029 POP on a non-empty list SHALL return resp_id_o = old head.
- If head equals tail, the list becomes empty (head=tail=NULL) regardless of req_id_i.
- Otherwise, head becomes req_id_i.
REQ-030 POP on an empty list SHALL return resp_err_o=1 and resp_id_o=NULL, with no state change.
REQ-031 PUSH on an empty list SHALL set head=tail=req_id_i and return resp_id_o=NULL.
REQ-032 PUSH on a non-empty list SHALL set tail=req_id_i and return resp_id_o = old tail; head is unchanged.
REQ-033 PUSH with req_id_i=NULL SHALL return resp_err_o=1 with no state change.
REQ-034 Any operation with req_list_i=0 or req_list_i>=NUM_LISTS SHALL return resp_err_o=1 with no state change.
REQ-035 When resp_err_o=0, resp_err_o and resp_id_o SHALL still be valid only while resp_valid_o=1; otherwise they SHALL be 0.

Reset
REQ-036 rst_i SHALL dominate all inputs in the cycle it is sampled high.
REQ-037 Reset values: req_ready_o=0, resp_valid_o=0, resp_id_o=0, resp_err_o=0, init_done_o=0; all head, tail and count registers 0; empty_o all 1.
REQ-038 Reset asserted mid-operation SHALL drop any pending response (resp_valid_o=0 on the next cycle) and restart INIT from index 0.

Configuration
REQ-039 With HACD_TOL_CNT_EN defined, the block SHALL keep a per-list CNT_W occupancy counter: +1 on a successful PUSH, -1 on a successful POP, driven on count_o.
REQ-040 With HACD_TOL_CNT_EN defined, a PUSH when count is 2^ID_W-1 SHALL return resp_err_o=1 with no state change.
REQ-041 Without HACD_TOL_CNT_EN, no counters SHALL be instantiated, count_o SHALL be tied to 0, and the overflow check SHALL be omitted.

Verification
REQ-042 Reset for 2 cycles, release, NUM_IFL=1 -> init_done_o high 5 cycles after release; FREE head=1, tail=4; lists 2-4 empty; count FREE=4 (macro on).
REQ-043 POP FREE, req_id_i=2 -> resp_id_o=1, err=0, FREE head=2; then PUSH UNCOMP id=1 -> resp_id_o=0, UNCOMP head=tail=1.
REQ-044 Back-to-back PUSH UNCOMP id=5, id=6 on consecutive cycles -> resp_id_o=0 then 5; tail=6, head=5.
REQ-045 POP INCOMP while empty -> resp_err_o=1, resp_id_o=0, no state change; POP on list code 0 and on list code 5 -> resp_err_o=1.
REQ-046 Pop FREE until head=tail=4, then POP with req_id_i=9 -> resp_id_o=4, FREE empty, empty_o[1]=1.
REQ-047 Assert rst_i in the cycle after a POP is accepted -> resp_valid_o=0 next cycle, req_ready_o=0, INIT reruns, FREE restored to head 1, tail 4.
